// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // Request fields kept for the whole flight; the RAM index is held separately
    // because its width depends on the RAM depth.
    typedef struct packed {
        logic        write;
        logic        err;
        logic [31:0] wdata;
    } req_t;

    // Misaligned or past the last RAM word.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// MEM-stage load/store port: valid/ready request, single-pulse response, busy.
interface dmem_wait_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous word RAM, one-cycle read latency, read port holds when idle.
module dmem_sp_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    // Write and registered read; rdata only moves on a read strobe.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with programmable wait states between accept and response.
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_wait_responder_if.slave  bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    req_t             req_q, cur;
    logic [IW-1:0]    idx_q, cur_idx;
    logic             accept, access;
    logic             err_q, rd_sel;
    logic             ram_we, ram_re;
    logic [31:0]      ram_rdata;

    assign accept = bus.req_valid && (state == IDLE);
    // The RAM access edge is the accept edge itself with no wait states,
    // otherwise the edge that leaves WAIT.
    assign access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));

    // Live request fields in IDLE, latched ones once in flight.
    always_comb begin
        cur     = req_q;
        cur_idx = idx_q;
        if (state == IDLE) begin
            cur.write = bus.req_write;
            cur.wdata = bus.req_wdata;
            cur.err   = addr_err(bus.req_addr, 32'(DEPTH_WORDS));
            cur_idx   = bus.req_addr[2 +: IW];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
            idx_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            req_q <= cur;
            idx_q <= cur_idx;
            cnt   <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response status registered on the access edge, held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q  <= 1'b0;
            rd_sel <= 1'b0;
        end else if (access) begin
            err_q  <= cur.err;
            rd_sel <= !cur.write && !cur.err;
        end
    end

    // Reset gates the strobes so a write landing on the reset edge is dropped.
    assign ram_we = access && !reset &&  cur.write && !cur.err;
    assign ram_re = access && !reset && !cur.write && !cur.err;

    // RAM read register only updates on a load, so it doubles as the rdata holder.
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rd_sel ? ram_rdata : 32'h0;

    dmem_sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IW          (IW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (cur_idx),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench: three responders (2, 0 and 3 wait states) driven by table, hand sequences
// and random traffic checked against a word-array memory model.
module tb_dmem_wait_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        rv [3], rw [3];
    logic [31:0] ra [3], rd [3];
    logic        rdy [3], vld [3], rer [3], bsy [3];
    logic [31:0] rrd [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [3][256];

    function automatic int wc(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        dmem_wait_responder_if bus ();
        assign bus.req_valid = rv[g];
        assign bus.req_write = rw[g];
        assign bus.req_addr  = ra[g];
        assign bus.req_wdata = rd[g];
        assign rdy[g] = bus.req_ready;
        assign vld[g] = bus.resp_valid;
        assign rrd[g] = bus.resp_rdata;
        assign rer[g] = bus.resp_err;
        assign bsy[g] = bus.busy;
        dmem_wait_responder #(
            .DEPTH_WORDS (256),
            .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One transaction; valid drops and fields are scrambled right after accept.
    task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output bit e, output int lat);
        int k;
        q = 32'h0; e = 1'b0; lat = -1;
        @(negedge clk);
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; rd[i] = d;
        k = 0;
        while (!rdy[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rdy[i]) begin
            chk("accept_timeout", 32'(rdy[i]), 32'd1);
            rv[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rv[i] = 1'b0; rw[i] = 1'($urandom); ra[i] = $urandom; rd[i] = $urandom;
        for (int c = 1; c <= 20; c++) begin
            if (vld[i]) begin
                lat = c; q = rrd[i]; e = rer[i];
                break;
            end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            chk("pulse_end", 32'(vld[i]), 32'd0);
        end
    endtask

    task automatic run(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exq, input bit exe, input string nm);
        logic [31:0] q;
        bit          e;
        int          lat;
        xact(i, w, a, d, q, e, lat);
        chk({nm, " rdata"}, q, exq);
        chk({nm, " err"}, 32'(e), 32'(exe));
        chk({nm, " latency"}, 32'(lat), 32'(wc(i) + 1));
    endtask

    typedef struct {
        int          inst;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    vec_t tv [16];

    initial begin
        int acc [2];
        int vc [2];
        int n, nv;

        tv[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tv[1]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{0, 1'b1, 32'h0,   32'h0BADF00D, 32'h0,        1'b0};
        tv[3]  = '{0, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
        tv[4]  = '{0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
        tv[5]  = '{0, 1'b1, 32'h13,  32'h12345678, 32'h0,        1'b1};
        tv[6]  = '{0, 1'b1, 32'h400, 32'h12345678, 32'h0,        1'b1};
        tv[7]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv[8]  = '{0, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0};
        tv[9]  = '{0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0};
        tv[10] = '{0, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0};
        tv[11] = '{0, 1'b0, 32'h3FE, 32'h0,        32'h0,        1'b1};
        tv[12] = '{2, 1'b1, 32'h8,   32'h00000011, 32'h0,        1'b0};
        tv[13] = '{2, 1'b0, 32'h8,   32'h0,        32'h00000011, 1'b0};
        tv[14] = '{1, 1'b0, 32'h402, 32'h0,        32'h0,        1'b1};
        tv[15] = '{1, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1};

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk("rst req_ready", 32'(rdy[i]), 32'd1);
            chk("rst resp_valid", 32'(vld[i]), 32'd0);
            chk("rst resp_rdata", rrd[i], 32'h0);
            chk("rst resp_err", 32'(rer[i]), 32'd0);
            chk("rst busy", 32'(bsy[i]), 32'd0);
        end

        // Table vectors: stores, loads, misaligned and out-of-range on all latencies
        for (int v = 0; v < 16; v++)
            run(tv[v].inst, tv[v].wr, tv[v].addr, tv[v].wdata, tv[v].rdata, tv[v].err,
                $sformatf("vec%0d", v));

        // Zero wait states, valid held high: accepts two cycles apart
        acc[0] = -100; acc[1] = -100; vc[0] = -50; vc[1] = -50; n = 0; nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vld[1] && nv < 2) begin vc[nv] = k; nv++; end
            if (n < 2) begin
                rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'(n * 4); rd[1] = 32'(n + 1);
            end else begin
                rv[1] = 1'b0;
            end
            if (rv[1] && rdy[1]) begin acc[n] = k; n++; end
        end
        chk("b2b accept gap", 32'(acc[1] - acc[0]), 32'd2);
        chk("b2b resp0 lat", 32'(vc[0] - acc[0]), 32'd1);
        chk("b2b resp1 lat", 32'(vc[1] - acc[1]), 32'd1);
        run(1, 1'b0, 32'h0, 32'h0, 32'd1, 1'b0, "b2b rd0");
        run(1, 1'b0, 32'h4, 32'h0, 32'd2, 1'b0, "b2b rd1");

        // Reset on the store's RAM write edge discards the store
        run(0, 1'b1, 32'h20, 32'hAA, 32'h0, 1'b0, "pre-reset st");
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rd[0] = 32'h55;
        chk("rr ready", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        @(negedge clk);
        chk("rr wait1 vld", 32'(vld[0]), 32'd0);
        @(negedge clk);
        chk("rr wait0 vld", 32'(vld[0]), 32'd0);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("rr post vld", 32'(vld[0]), 32'd0);
        chk("rr post ready", 32'(rdy[0]), 32'd1);
        chk("rr post busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr no resp", 32'(vld[0]), 32'd0);
        end
        run(0, 1'b0, 32'h20, 32'h0, 32'hAA, 1'b0, "rr readback");

        // busy/req_ready trace over a 3-wait load; rdata holds after the pulse
        @(negedge clk);
        rv[2] = 1'b1; rw[2] = 1'b0; ra[2] = 32'h8;
        @(posedge clk); #1;
        rv[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("trace busy c%0d", k), 32'(bsy[2]), 32'(k <= 4));
            chk($sformatf("trace ready c%0d", k), 32'(rdy[2]), 32'(k > 4));
            chk($sformatf("trace vld c%0d", k), 32'(vld[2]), 32'(k == 4));
            if (k >= 4) chk($sformatf("trace rdata c%0d", k), rrd[2], 32'h11);
            @(posedge clk); #1;
        end

        // Valid dropped and fields changed during WAIT: latched store still lands
        run(0, 1'b1, 32'h24, 32'h77, 32'h0, 1'b0, "drop st");
        run(0, 1'b0, 32'h24, 32'h0, 32'h77, 1'b0, "drop rd");
        run(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "drop other");

        // Random traffic against the word-array model
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 16; w++) begin
                mdl[i][w] = $urandom;
                run(i, 1'b1, 32'(w * 4), mdl[i][w], 32'h0, 1'b0, "fill");
            end
        for (int t = 0; t < 60; t++) begin
            int          i, kind;
            bit          w, e;
            logic [31:0] a, d, q;
            i    = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            w    = 1'($urandom);
            d    = $urandom;
            if (kind < 7)       a = 32'($urandom_range(0, 15) * 4);
            else if (kind == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else                a = 32'((256 + $urandom_range(0, 1000)) * 4 + $urandom_range(0, 3));
            e = (a % 4 != 0) || (a / 4 >= 256);
            q = (w || e) ? 32'h0 : mdl[i][a / 4];
            run(i, w, a, d, q, e, $sformatf("rnd%0d", t));
            if (w && !e) mdl[i][a / 4] = d;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
